// File: rtl/uart_pkg.sv
// Shared constants for the UART receive controller.
//   OVERSAMPLE / FRAME_BITS : line timing (16x oversampling, 10-bit character)
//   ST_WAIT / ST_CLEAR      : handshake FSM encoding
//   div_calc()              : clock divider ratio from clock and baud rate
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int FRAME_BITS = 10;

    localparam logic [1:0] ST_WAIT  = 2'b00;
    localparam logic [1:0] ST_CLEAR = 2'b01;

    // Integer-truncated ratio: 50 MHz / (115200*16) gives 27.
    function automatic int div_calc(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock byte FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   push, din       : write request and data (ignored when full unless popping)
//   pop             : read request (ignored when empty)
//   dout            : head entry, registered storage
//   full, empty     : status
//   count           : occupancy 0..DEPTH
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wptr_q, rptr_q;
    logic [AW:0]                 count_q, count_d;
    logic                        wr_ok, rd_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    assign wr_ok = push & (~full | pop);
    assign rd_ok = pop & ~empty;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is reset so that dout reads 0 while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (rd_ok)
                rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer and byte buffer.
//   clk_50m, rst     : clock, asynchronous active-high reset
//   en               : enables the 16x oversample strobe
//   rx_clken         : 1-cycle strobe every DIV clocks to the receiver
//   rx_rdy, rx_data  : receiver byte-ready flag and byte
//   rx_rdy_clr       : clear request back to the receiver
//   m_data, m_valid, m_ready : FIFO head stream
//   fifo_count       : occupancy
//   overrun, clr_overrun     : sticky drop flag and its clear
//   idle_timeout     : pulse after IDLE_CHARS idle character times following a byte
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int IDLE_CHARS = 4
) (
    input  logic                            clk_50m,
    input  logic                            rst,
    input  logic                            en,
    output logic                            rx_clken,
    input  logic                            rx_rdy,
    input  logic [7:0]                      rx_data,
    output logic                            rx_rdy_clr,
    output logic [7:0]                      m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overrun,
    input  logic                            clr_overrun,
    output logic                            idle_timeout
);

    localparam int DIV        = div_calc(CLK_HZ, BAUD);
    localparam int DW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDLE_TICKS = OVERSAMPLE * FRAME_BITS * IDLE_CHARS;
    localparam int IW         = $clog2(IDLE_TICKS);

    // ---------------- divider ----------------
    logic [DW-1:0] div_q, div_d;
    logic          div_end;

    assign div_end  = (div_q == DW'(DIV - 1));
    assign rx_clken = en & div_end;

    always_comb begin
        div_d = '0;
        if (en && !div_end)
            div_d = div_q + DW'(1);
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    // ---------------- handshake FSM ----------------
    logic [1:0] state_q, state_d;
    logic       rdy_clr_q, rdy_clr_d;
    logic       capture;

    // Bytes are taken only in WAIT, so one rx_rdy high period yields one capture.
    assign capture = (state_q == ST_WAIT) & rx_rdy;

    always_comb begin
        state_d   = state_q;
        rdy_clr_d = rdy_clr_q;
        case (state_q)
            ST_WAIT: if (rx_rdy) begin
                state_d   = ST_CLEAR;
                rdy_clr_d = 1'b1;
            end
            ST_CLEAR: if (!rx_rdy) begin
                state_d   = ST_WAIT;
                rdy_clr_d = 1'b0;
            end
            default: begin
                state_d   = ST_WAIT;
                rdy_clr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            rdy_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_clr_q <= rdy_clr_d;
        end
    end

    assign rx_rdy_clr = rdy_clr_q;

    // ---------------- FIFO ----------------
    logic fifo_full, fifo_empty;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk_50m),
        .rst   (rst),
        .push  (capture),
        .din   (rx_data),
        .pop   (m_ready),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid = ~fifo_empty;

    // ---------------- overrun ----------------
    logic overrun_q, overrun_d, drop;

    // A simultaneous pop makes room, so only an un-popped full FIFO drops.
    assign drop = capture & fifo_full & ~m_ready;

    always_comb begin
        overrun_d = overrun_q;
        if (drop)             overrun_d = 1'b1;
        else if (clr_overrun) overrun_d = 1'b0;
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;

    // ---------------- idle timer ----------------
    logic [IW-1:0] idle_q, idle_d;
    logic          armed_q, armed_d;
    logic          idle_pulse_q, idle_pulse_d;

    always_comb begin
        idle_d       = idle_q;
        armed_d      = armed_q;
        idle_pulse_d = 1'b0;
        if (capture) begin
            // Capture takes priority over a terminal tick in the same cycle.
            idle_d  = '0;
            armed_d = 1'b1;
        end else if (armed_q && rx_clken) begin
            if (idle_q == IW'(IDLE_TICKS - 1)) begin
                idle_d       = '0;
                armed_d      = 1'b0;
                idle_pulse_d = 1'b1;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            idle_q       <= '0;
            armed_q      <= 1'b0;
            idle_pulse_q <= 1'b0;
        end else begin
            idle_q       <= idle_d;
            armed_q      <= armed_d;
            idle_pulse_q <= idle_pulse_d;
        end
    end

    assign idle_timeout = idle_pulse_q;

endmodule
